// File: rtl/data_mem_unit_if.sv
// Request/response bundle between the core control path and the data-memory stage.
// The core drives the request side and the memory unit drives the response side.
interface data_mem_unit_if;
  logic        memread;
  logic        memwrite;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] read_data;
  logic        busy;
  logic        done;
  logic        misaligned;

  modport master (
    output memread, memwrite, funct3, addr, store_data,
    input  read_data, busy, done, misaligned
  );

  modport slave (
    input  memread, memwrite, funct3, addr, store_data,
    output read_data, busy, done, misaligned
  );
endinterface

// File: rtl/data_mem_unit.sv
// RV32I data-memory stage: registered two-cycle loads/stores on a word RAM,
// reporting misaligned or illegal requests with a one-cycle fault response.
module data_mem_unit #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  data_mem_unit_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_r, next_state_s;
  logic [2:0]  funct3_r;
  logic [1:0]  addr_lo_r;
  logic [AW-1:0] idx_r;
  logic [31:0] store_data_r;
  logic        is_store_r;
  logic [31:0] read_data_r;
  logic        busy_r, done_r, misaligned_r;
  logic        req_s, fault_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;
  logic [31:0] mem_r [DEPTH_WORDS];

  function automatic logic access_fault(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] a_lo);
    logic bad_s;
    bad_s = 1'b0;
    case (f3)
      3'b000:         bad_s = 1'b0;
      3'b001:         bad_s = a_lo[0];
      3'b010:         bad_s = (a_lo != 2'b00);
      3'b100:         bad_s = is_store;
      3'b101:         bad_s = is_store | a_lo[0];
      default:        bad_s = 1'b1;
    endcase
    return bad_s;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] a_lo);
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] res_s;
    byte_s = word[{a_lo, 3'b000} +: 8];
    half_s = a_lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res_s = {{24{byte_s[7]}}, byte_s};
      3'b001:  res_s = {{16{half_s[15]}}, half_s};
      3'b100:  res_s = {24'd0, byte_s};
      3'b101:  res_s = {16'd0, half_s};
      default: res_s = word;
    endcase
    return res_s;
  endfunction

  assign req_s   = bus.memwrite | bus.memread;
  assign fault_s = access_fault(bus.memwrite, bus.funct3, bus.addr[1:0]);

  // Next-state decode; faults skip ACCESS and answer directly.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          next_state_s = fault_s ? RESP : ACCESS;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCESS:  next_state_s = RESP;
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Byte-lane enables and replicated write data for the latched store.
  always_comb begin
    be_s    = 4'b1111;
    wdata_s = store_data_r;
    case (funct3_r[1:0])
      2'b00: begin
        be_s    = 4'b0001 << addr_lo_r;
        wdata_s = {4{store_data_r[7:0]}};
      end
      2'b01: begin
        be_s    = addr_lo_r[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{store_data_r[15:0]}};
      end
      default: begin
        be_s    = 4'b1111;
        wdata_s = store_data_r;
      end
    endcase
  end

  // FSM state, request latch and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      funct3_r     <= 3'd0;
      addr_lo_r    <= 2'd0;
      idx_r        <= '0;
      store_data_r <= 32'd0;
      is_store_r   <= 1'b0;
      read_data_r  <= 32'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      misaligned_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      busy_r       <= (next_state_s == ACCESS);
      done_r       <= (next_state_s == RESP);
      misaligned_r <= (state_r == IDLE) & req_s & fault_s;
      if (state_r == IDLE && req_s) begin
        funct3_r     <= bus.funct3;
        addr_lo_r    <= bus.addr[1:0];
        idx_r        <= bus.addr[AW+1:2];
        store_data_r <= bus.store_data;
        is_store_r   <= bus.memwrite;
        if (fault_s) begin
          read_data_r <= 32'd0;
        end
      end else if (state_r == ACCESS && !is_store_r) begin
        read_data_r <= load_extract(mem_r[idx_r], funct3_r, addr_lo_r);
      end
    end
  end

  // RAM write port; reset on the ACCESS edge suppresses the store.
  always_ff @(posedge clk) begin
    if (rst_n && state_r == ACCESS && is_store_r) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_r[idx_r][8*i +: 8] <= wdata_s[8*i +: 8];
        end
      end
    end
  end

  assign bus.read_data  = read_data_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.misaligned = misaligned_r;

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit: driver pushes expected responses, a
// negedge monitor pops and compares them whenever done is presented.
module tb_data_mem_unit;

  typedef struct packed {
    logic [31:0] rd;
    logic        mis;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [31:0] last_rd;

  data_mem_unit_if bus ();

  data_mem_unit #(.DEPTH_WORDS(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no response");
      end else begin
        mon_e = exp_q.pop_front();
        check("read_data", bus.read_data, mon_e.rd);
        check("misaligned", {31'd0, bus.misaligned}, {31'd0, mon_e.mis});
      end
    end
  end

  task automatic wait_done(input int lat, input string name);
    int cyc;
    cyc = 0;
    while (cyc < 6) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1 && lat == 2) check({name, "_busy"}, {31'd0, bus.busy}, 32'd1);
      if (bus.done === 1'b1) break;
    end
    check({name, "_latency"}, cyc, lat);
    check({name, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
    @(posedge clk);
  endtask

  task automatic do_req(input string name, input logic wr, input logic rd, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_data, input logic exp_mis);
    exp_t e;
    @(negedge clk);
    bus.memwrite   = wr;
    bus.memread    = rd;
    bus.funct3     = f3;
    bus.addr       = a;
    bus.store_data = d;
    if (exp_mis) begin
      e.rd = 32'd0;
      last_rd = 32'd0;
    end else if (wr) begin
      e.rd = last_rd;
    end else begin
      e.rd = exp_data;
      last_rd = exp_data;
    end
    e.mis = exp_mis;
    exp_q.push_back(e);
    wait_done(exp_mis ? 1 : 2, name);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_read_data"}, bus.read_data, 32'd0);
    check({name, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({name, "_done"}, {31'd0, bus.done}, 32'd0);
    check({name, "_misaligned"}, {31'd0, bus.misaligned}, 32'd0);
  endtask

  initial begin
    exp_t e;
    checks = 0;
    failures = 0;
    last_rd = 32'd0;
    rst_n = 1'b0;
    bus.memread = 1'b0;
    bus.memwrite = 1'b0;
    bus.funct3 = 3'd0;
    bus.addr = 32'd0;
    bus.store_data = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    do_req("sw_0", 1'b1, 1'b0, 3'b010, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0);

    // Reset held for two cycles with a load pending, then released.
    @(negedge clk);
    rst_n = 1'b0;
    bus.memread = 1'b1;
    bus.funct3 = 3'b010;
    bus.addr = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    last_rd = 32'd0;
    e.rd = 32'hCAFEF00D;
    e.mis = 1'b0;
    exp_q.push_back(e);
    last_rd = 32'hCAFEF00D;
    rst_n = 1'b1;
    wait_done(2, "reset_release_lw");

    do_req("sw_10", 1'b1, 1'b0, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    do_req("lw_10", 1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    do_req("lb_13", 1'b0, 1'b1, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
    do_req("lbu_13", 1'b0, 1'b1, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0);
    do_req("lh_10", 1'b0, 1'b1, 3'b001, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b0);
    do_req("lhu_12", 1'b0, 1'b1, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);
    do_req("sb_11", 1'b1, 1'b0, 3'b000, 32'h11, 32'hAABBCC55, 32'h0, 1'b0);
    do_req("lw_sb", 1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0);
    do_req("sh_12", 1'b1, 1'b0, 3'b001, 32'h12, 32'hFFFF1234, 32'h0, 1'b0);
    do_req("lw_sh", 1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0);

    do_req("lw_mis", 1'b0, 1'b1, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1);
    do_req("lw_after_lwmis", 1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0);
    do_req("sh_mis", 1'b1, 1'b0, 3'b001, 32'h11, 32'h00009999, 32'h0, 1'b1);
    do_req("lw_after_shmis", 1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0);
    do_req("ld_f3_011", 1'b0, 1'b1, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    do_req("st_f3_100", 1'b1, 1'b0, 3'b100, 32'h10, 32'h77777777, 32'h0, 1'b1);
    do_req("lw_after_illegal", 1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 32'h123455EF, 1'b0);

    do_req("sw_wrap", 1'b1, 1'b0, 3'b010, 32'h400, 32'h12345678, 32'h0, 1'b0);
    do_req("lw_wrap", 1'b0, 1'b1, 3'b010, 32'h000, 32'h0, 32'h12345678, 1'b0);
    do_req("sw_20", 1'b1, 1'b0, 3'b010, 32'h20, 32'h11111111, 32'h0, 1'b0);
    do_req("rw_prio", 1'b1, 1'b1, 3'b010, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0);
    do_req("lw_prio", 1'b0, 1'b1, 3'b010, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0);

    // Store aborted by reset sampled on its ACCESS edge.
    @(negedge clk);
    bus.memwrite = 1'b1;
    bus.memread = 1'b0;
    bus.funct3 = 3'b010;
    bus.addr = 32'h20;
    bus.store_data = 32'h0BADF00D;
    @(posedge clk);
    #1;
    check("rst_mid_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("rst_mid");
    bus.memwrite = 1'b0;
    rst_n = 1'b1;
    last_rd = 32'd0;
    @(posedge clk);
    do_req("lw_after_rst_mid", 1'b0, 1'b1, 3'b010, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0);

    repeat (3) @(posedge clk);
    check("pending_responses", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule
